cia_bus_arbiter: RTL and testbench

- Shares one mos6526 register interface between two masters: the CPU port (fixed priority, cannot stall) and a host/debug port (req/ack handshake, e.g. a monitor or keyboard injector).
- Host accesses are slotted into cycles where the CPU is not selecting the CIA.
- Host read data is captured at a fixed latency after issue; reads are reissued if the CPU intrudes on the capture window.
- Sits between the CPU address decode and the CIA instance.

---
 rtl/cia_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cia_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cia_bus_arbiter.sv
// Lets a host/debug port share the mos6526 register bus with the CPU. The CPU always has priority.
// Optional macro CIA_ARB_ICR_GUARD_EN rejects host reads of register 4'hD (the ICR).
module cia_bus_arbiter #(
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 255,
   parameter int STARVE_W   = 8
) (
   input  logic       clk,
   input  logic       res,
   input  logic       cpu_cs_n,
   input  logic       cpu_rw,
   input  logic [3:0] cpu_rs,
   input  logic [7:0] cpu_db,
   input  logic       host_req,
   input  logic       host_rw,
   input  logic [3:0] host_rs,
   input  logic [7:0] host_wdata,
   output logic       host_ack,
   output logic [7:0] host_rdata,
   output logic       host_err,
   output logic       host_starve,
   output logic       busy,
   output logic       cia_cs_n,
   output logic       cia_rw,
   output logic [3:0] cia_rs,
   output logic [7:0] cia_db_in,
   input  logic [7:0] cia_db_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam logic [2:0]          LAT_INIT   = 3'(RD_LAT);

   state_t              state_reg, state_next;
   logic                lat_rw_reg, lat_rw_next;
   logic [3:0]          lat_rs_reg, lat_rs_next;
   logic [7:0]          lat_wdata_reg, lat_wdata_next;
   logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
   logic                starve_reg, starve_next;
   logic [2:0]          lat_cnt_reg, lat_cnt_next;
   logic [7:0]          rdata_reg, rdata_next;
`ifdef CIA_ARB_ICR_GUARD_EN
   logic                err_reg, err_next;
`endif

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_reg      <= IDLE;
         lat_rw_reg     <= 1'b0;
         lat_rs_reg     <= 4'h0;
         lat_wdata_reg  <= 8'h00;
         starve_cnt_reg <= '0;
         starve_reg     <= 1'b0;
         lat_cnt_reg    <= 3'd0;
         rdata_reg      <= 8'h00;
`ifdef CIA_ARB_ICR_GUARD_EN
         err_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         lat_rw_reg     <= lat_rw_next;
         lat_rs_reg     <= lat_rs_next;
         lat_wdata_reg  <= lat_wdata_next;
         starve_cnt_reg <= starve_cnt_next;
         starve_reg     <= starve_next;
         lat_cnt_reg    <= lat_cnt_next;
         rdata_reg      <= rdata_next;
`ifdef CIA_ARB_ICR_GUARD_EN
         err_reg        <= err_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      lat_rw_next     = lat_rw_reg;
      lat_rs_next     = lat_rs_reg;
      lat_wdata_next  = lat_wdata_reg;
      starve_cnt_next = starve_cnt_reg;
      starve_next     = starve_reg;
      lat_cnt_next    = lat_cnt_reg;
      rdata_next      = rdata_reg;
`ifdef CIA_ARB_ICR_GUARD_EN
      err_next        = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (host_req) begin
               lat_rw_next     = host_rw;
               lat_rs_next     = host_rs;
               lat_wdata_next  = host_wdata;
               starve_cnt_next = '0;
               starve_next     = 1'b0;
               state_next      = ISSUE;
`ifdef CIA_ARB_ICR_GUARD_EN
               err_next        = 1'b0;
               // A host read of the ICR would clear the CPU's pending interrupt flags.
               if (!host_rw && host_rs == 4'hD) begin
                  err_next   = 1'b1;
                  state_next = DONE;
               end
`endif
            end
         end
         ISSUE: begin
            if (!cpu_cs_n) begin
               if (starve_cnt_reg != STARVE_LIM) begin
                  starve_cnt_next = starve_cnt_reg + 1'b1;
                  if (starve_cnt_reg == STARVE_LIM - 1'b1)
                     starve_next = 1'b1;
               end
            end else if (lat_rw_reg) begin
               state_next = DONE;
            end else begin
               lat_cnt_next = LAT_INIT;
               state_next   = WAIT;
            end
         end
         WAIT: begin
            // A CPU access may have changed the register, so the read is redone.
            if (!cpu_cs_n) begin
               state_next = ISSUE;
            end else if (lat_cnt_reg == 3'd1) begin
               rdata_next = cia_db_out;
               state_next = DONE;
            end else begin
               lat_cnt_next = lat_cnt_reg - 3'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign host_ack    = (state_reg == DONE);
   assign host_rdata  = rdata_reg;
   assign host_starve = starve_reg;
   assign busy        = (state_reg != IDLE);
`ifdef CIA_ARB_ICR_GUARD_EN
   assign host_err    = (state_reg == DONE) && err_reg;
`else
   assign host_err    = 1'b0;
`endif

   always_comb begin
      cia_cs_n  = 1'b1;
      cia_rw    = 1'b0;
      cia_rs    = 4'h0;
      cia_db_in = 8'h00;
      if (!cpu_cs_n) begin
         cia_cs_n  = 1'b0;
         cia_rw    = cpu_rw;
         cia_rs    = cpu_rs;
         cia_db_in = cpu_db;
      end else if (state_reg == ISSUE) begin
         cia_cs_n  = 1'b0;
         cia_rw    = lat_rw_reg;
         cia_rs    = lat_rs_reg;
         cia_db_in = lat_wdata_reg;
      end
   end

endmodule

// File: tb/tb_cia_bus_arbiter.sv
// Randomized bench for cia_bus_arbiter: a per-cycle expectation table is built up front from the
// CPU chip-select schedule and the transaction rules, then compared against the DUT every cycle.
module tb_cia_bus_arbiter;

   localparam int RD_LAT     = 2;
   localparam int STARVE_MAX = 4;
   localparam int N          = 700;
`ifdef CIA_ARB_ICR_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       cpu_cs_n = 1'b1, cpu_rw = 1'b0;
   logic [3:0] cpu_rs = 4'h0;
   logic [7:0] cpu_db = 8'h00;
   logic       host_req = 1'b0, host_rw = 1'b0;
   logic [3:0] host_rs = 4'h0;
   logic [7:0] host_wdata = 8'h00;
   logic       host_ack, host_err, host_starve, busy;
   logic [7:0] host_rdata;
   logic       cia_cs_n, cia_rw;
   logic [3:0] cia_rs;
   logic [7:0] cia_db_in;
   logic [7:0] cia_db_out = 8'h00;

   cia_bus_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .STARVE_W(8)) dut (
      .clk(clk), .res(res),
      .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_db(cpu_db),
      .host_req(host_req), .host_rw(host_rw), .host_rs(host_rs), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
      .host_starve(host_starve), .busy(busy),
      .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in),
      .cia_db_out(cia_db_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stimulus schedule
   bit       cs_n_a[N];
   bit       cpu_rw_a[N];
   bit [3:0] cpu_rs_a[N];
   bit [7:0] cpu_db_a[N];
   bit [7:0] dbo_a[N];
   bit       req_a[N];
   bit       hrw_a[N];
   bit [3:0] hrs_a[N];
   bit [7:0] hwd_a[N];
   // Expectations
   bit       e_busy[N], e_ack[N], e_err[N], e_starve[N], e_hdrv[N];
   bit [7:0] e_rdata[N];

   int  t, r, c, ack, blk, intr, s, txn;
   bit  rw, err, done;
   bit [3:0] rs;
   bit [7:0] wd, rd_cur;
   bit       x_cs_n, x_rw;
   bit [3:0] x_rs;
   bit [7:0] x_db;

   initial begin
      for (int i = 0; i < N; i++) begin
         cs_n_a[i]   = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
         cpu_rw_a[i] = 1'($urandom);
         cpu_rs_a[i] = 4'($urandom);
         cpu_db_a[i] = 8'($urandom);
         dbo_a[i]    = 8'($urandom);
      end
      for (int i = 3; i < 13; i++) cs_n_a[i] = 1'b0;     // guaranteed starvation early on
      repeat (6) begin
         s = $urandom_range(20, N - 200);
         for (int k = 0; k < 10; k++) cs_n_a[s + k] = 1'b0;
      end
      for (int i = N - 80; i < N; i++) cs_n_a[i] = 1'b1;

      // Walk the transactions against the CPU schedule.
      t = 2;
      rd_cur = 8'h00;
      while (t < N - 100) begin
         r  = t + $urandom_range(0, 2);
         rw = 1'($urandom);
         rs = ($urandom_range(0, 5) == 0) ? 4'hD : 4'($urandom);
         wd = 8'($urandom);
         err = 1'b0;
         for (int x = r + 1; x < N; x++) e_starve[x] = 1'b0;
         if (GUARD && !rw && rs == 4'hD) begin
            ack = r + 1;
            err = 1'b1;
         end else begin
            c = r + 1;
            blk = 0;
            done = 1'b0;
            while (!done) begin
               while (!cs_n_a[c]) begin
                  blk++;
                  if (blk == STARVE_MAX)
                     for (int x = c + 1; x < N; x++) e_starve[x] = 1'b1;
                  c++;
               end
               e_hdrv[c] = 1'b1;
               if (rw) begin
                  ack = c + 1;
                  done = 1'b1;
               end else begin
                  intr = -1;
                  for (int j = 1; j <= RD_LAT; j++)
                     if (intr < 0 && !cs_n_a[c + j]) intr = c + j;
                  if (intr >= 0) begin
                     c = intr + 1;
                  end else begin
                     rd_cur = dbo_a[c + RD_LAT];
                     ack = c + RD_LAT + 1;
                     done = 1'b1;
                  end
               end
            end
            if (!rw) for (int x = ack; x < N; x++) e_rdata[x] = rd_cur;
         end
         for (int x = r; x < ack; x++) begin
            req_a[x] = 1'b1;
            hrw_a[x] = rw;
            hrs_a[x] = rs;
            hwd_a[x] = wd;
         end
         for (int x = r + 1; x <= ack; x++) e_busy[x] = 1'b1;
         e_ack[ack] = 1'b1;
         e_err[ack] = err;
         t = ack + 1;
      end

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_ack", host_ack, 0);
      check_val("rst_err", host_err, 0);
      check_val("rst_starve", host_starve, 0);
      check_val("rst_rdata", host_rdata, 0);
      check_val("rst_cs_n", cia_cs_n, 1);
      res = 1'b0;

      txn = 0;
      for (int i = 0; i < N; i++) begin
         cpu_cs_n   = cs_n_a[i];
         cpu_rw     = cpu_rw_a[i];
         cpu_rs     = cpu_rs_a[i];
         cpu_db     = cpu_db_a[i];
         cia_db_out = dbo_a[i];
         host_req   = req_a[i];
         host_rw    = req_a[i] ? hrw_a[i] : 1'($urandom);
         host_rs    = req_a[i] ? hrs_a[i] : 4'($urandom);
         host_wdata = req_a[i] ? hwd_a[i] : 8'($urandom);
         #1;
         if (!cs_n_a[i]) begin
            x_cs_n = 1'b0; x_rw = cpu_rw_a[i]; x_rs = cpu_rs_a[i]; x_db = cpu_db_a[i];
         end else if (e_hdrv[i]) begin
            x_cs_n = 1'b0; x_rw = hrw_a[i]; x_rs = hrs_a[i]; x_db = hwd_a[i];
         end else begin
            x_cs_n = 1'b1; x_rw = 1'b0; x_rs = 4'h0; x_db = 8'h00;
         end
         check_val($sformatf("c%0d ack", i), host_ack, e_ack[i]);
         check_val($sformatf("c%0d err", i), host_err, e_err[i]);
         check_val($sformatf("c%0d busy", i), busy, e_busy[i]);
         check_val($sformatf("c%0d starve", i), host_starve, e_starve[i]);
         check_val($sformatf("c%0d rdata", i), host_rdata, e_rdata[i]);
         check_val($sformatf("c%0d cia_cs_n", i), cia_cs_n, x_cs_n);
         check_val($sformatf("c%0d cia_rw", i), cia_rw, x_rw);
         check_val($sformatf("c%0d cia_rs", i), cia_rs, x_rs);
         check_val($sformatf("c%0d cia_db_in", i), cia_db_in, x_db);
         if (e_ack[i]) begin
            $display("txn %0d ack at cycle %0d: err=%0d starve=%0d rdata=%02h",
                     txn, i, e_err[i], e_starve[i], e_rdata[i]);
            txn++;
         end
         @(negedge clk);
      end

      // Asynchronous reset while a read sits in WAIT aborts it with no ack.
      cpu_cs_n = 1'b1;
      host_req = 1'b1; host_rw = 1'b0; host_rs = 4'h0;
      @(negedge clk);
      host_req = 1'b0;
      @(negedge clk);
      #1;
      check_val("wait_busy", busy, 1);
      #2 res = 1'b1;
      #1;
      check_val("arst_busy", busy, 0);
      check_val("arst_ack", host_ack, 0);
      repeat (2) begin
         @(negedge clk);
         check_val("arst_hold_ack", host_ack, 0);
      end
      res = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("post_arst_ack", host_ack, 0);
         check_val("post_arst_busy", busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
